dmem_responder: RTL and testbench

- Data-memory responder at the MEM stage of the pipelined CPU.
- Consumes the memory request that the EX/MEM pipeline register presents: MemRead, MemWrite, ALU address and store data.
- Services each request with a fixed, parameterised access latency and holds the upstream pipeline with a stall until the access completes.
- Returns load data to the MEM/WB register in the completion cycle.

---
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: services one load or store at a time
// with a fixed access latency, stalls the upstream pipeline until the access
// completes, and returns load data in the completion cycle.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [3:0]  cnt;
    logic [3:0]  cntNext;

    logic          opWrite;
    logic [AW-1:0] idxQ;
    logic [31:0]   wdataQ;
    logic [31:0]   rdataQ;
    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          illegal;
    logic [AW-1:0] idx;

    logic          accept;
    logic          complete;
    logic          compWrite;
    logic [AW-1:0] compIdx;
    logic [31:0]   compData;

    // Decode the incoming request: word index and the three rejection reasons
    always_comb begin
        req     = MemRead_i | MemWrite_i;
        idx     = addr_i[AW+1:2];
        illegal = (MemRead_i & MemWrite_i)
                | (addr_i[1:0] != 2'b00)
                | ({2'b00, addr_i[31:2]} >= 32'(DEPTH));
    end

    // Next-state and handshake logic; with LATENCY=1 the access finishes in the accept cycle
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        stall_o   = 1'b0;
        ack_o     = 1'b0;
        err_o     = 1'b0;
        accept    = 1'b0;
        complete  = 1'b0;
        compWrite = opWrite;
        compIdx   = idxQ;
        compData  = wdataQ;
        if (start_i) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (illegal) begin
                            err_o = 1'b1;
                        end else if (LATENCY == 1) begin
                            ack_o     = 1'b1;
                            complete  = 1'b1;
                            compWrite = MemWrite_i;
                            compIdx   = idx;
                            compData  = wdata_i;
                        end else begin
                            stall_o   = 1'b1;
                            accept    = 1'b1;
                            cntNext   = 4'(LATENCY - 1);
                            stateNext = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt > 4'd1) begin
                        stall_o = 1'b1;
                        cntNext = cnt - 4'd1;
                    end else begin
                        ack_o     = 1'b1;
                        complete  = 1'b1;
                        cntNext   = 4'd0;
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Load data comes straight from the array in the completion cycle, otherwise the last load
    always_comb begin
        rdata_o = (complete && !compWrite) ? mem[compIdx] : rdataQ;
    end

    // Control state plus the latched request that BUSY works from
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            opWrite <= 1'b0;
            idxQ    <= '0;
            wdataQ  <= 32'd0;
            rdataQ  <= 32'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (accept) begin
                opWrite <= MemWrite_i;
                idxQ    <= idx;
                wdataQ  <= wdata_i;
            end
            if (complete && !compWrite) begin
                rdataQ <= mem[compIdx];
            end
        end
    end

    // Storage array; a store lands at the edge closing its completion cycle
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (complete && compWrite) begin
            mem[compIdx] <= compData;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=3 instance with a load-data
// scoreboard, plus a LATENCY=1 instance for the single-cycle build.
module tb_dmem_responder;

    localparam int LAT = 3;

    typedef struct {
        bit          isLoad;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        startN;
    logic        memRead, memWrite;
    logic [31:0] addr, wdata, rdata;
    logic        ack, stall, err;

    logic        rd1, wr1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        ack1, stall1, err1;

    exp_t        sbq[$];
    logic [31:0] refMem[32];
    int          passCount;
    int          checkCount;

    dmem_responder #(.DEPTH(32), .LATENCY(LAT)) dut (
        .clk_i(clk), .start_i(startN), .MemRead_i(memRead), .MemWrite_i(memWrite),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack),
        .stall_o(stall), .err_o(err)
    );

    dmem_responder #(.DEPTH(32), .LATENCY(1)) dut1 (
        .clk_i(clk), .start_i(startN), .MemRead_i(rd1), .MemWrite_i(wr1),
        .addr_i(addr1), .wdata_i(wdata1), .rdata_o(rdata1), .ack_o(ack1),
        .stall_o(stall1), .err_o(err1)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Scoreboard: every ack of the main instance retires the oldest expected access
    always @(negedge clk) begin
        exp_t e;
        if (startN && ack) begin
            checkCount++;
            if (sbq.size() == 0) begin
                $display("[TB] FAIL sb_unexpected_ack: got ack with empty queue, required no ack");
            end else begin
                e = sbq.pop_front();
                if (e.isLoad && rdata !== e.data)
                    $display("[TB] FAIL sb_load_data: got %h required %h", rdata, e.data);
                else
                    passCount++;
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = d;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        drive(rd, wr, a, d);
        e.isLoad = rd;
        e.data   = rd ? refMem[a[6:2]] : d;
        sbq.push_back(e);
        if (wr) refMem[a[6:2]] = d;
    endtask

    task automatic runAccess(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        issue(rd, wr, a, d);
        repeat (LAT) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) refMem[i] = 32'd0;
        sbq.delete();
    endtask

    task automatic test_reset();
        startN = 1'b0;
        drive(1'b1, 1'b1, 32'h13, 32'h0);
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkCount++;
            if ({err, stall, ack} !== 3'b000)
                $display("[TB] FAIL reset_flags: got err/stall/ack %b required 000", {err, stall, ack});
            else passCount++;
            @(posedge clk); #1;
        end
        startN = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        clearModel();
        @(negedge clk);
        checkCount++;
        if (rdata !== 32'd0 || {err, stall, ack} !== 3'b000)
            $display("[TB] FAIL reset_idle: got rdata %h flags %b required 0 and 000", rdata, {err, stall, ack});
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        for (int c = 0; c < 6; c++) begin
            if (c == 0) issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
            if (c == 3) issue(1'b1, 1'b0, 32'h10, 32'h0);
            @(negedge clk);
            checkCount++;
            if (stall !== ((c % 3) < 2) || ack !== ((c % 3) == 2))
                $display("[TB] FAIL store_load_timing c%0d: got stall %b ack %b required %b %b",
                         c, stall, ack, (c % 3) < 2, (c % 3) == 2);
            else passCount++;
            if (c == 5) begin
                checkCount++;
                if (rdata !== 32'hDEADBEEF)
                    $display("[TB] FAIL store_load_data: got %h required deadbeef", rdata);
                else passCount++;
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_illegal();
        logic [33:0] pats[3];
        pats[0] = {1'b1, 1'b0, 32'h13};
        pats[1] = {1'b1, 1'b0, 32'h80};
        pats[2] = {1'b1, 1'b1, 32'h10};
        for (int p = 0; p < 3; p++) begin
            drive(pats[p][33], pats[p][32], pats[p][31:0], 32'h5555AAAA);
            @(negedge clk);
            checkCount++;
            if ({err, stall, ack} !== 3'b100)
                $display("[TB] FAIL illegal_%0d: got err/stall/ack %b required 100", p, {err, stall, ack});
            else passCount++;
            @(posedge clk); #1;
            drive(1'b0, 1'b0, 32'd0, 32'd0);
            @(negedge clk);
            checkCount++;
            if ({err, stall, ack} !== 3'b000)
                $display("[TB] FAIL illegal_after_%0d: got err/stall/ack %b required 000", p, {err, stall, ack});
            else passCount++;
            @(posedge clk); #1;
        end
        runAccess(1'b1, 1'b0, 32'h00, 32'h0);
    endtask

    task automatic test_busy_change();
        runAccess(1'b0, 1'b1, 32'h0C, 32'hA5A5A5A5);
        issue(1'b1, 1'b0, 32'h0C, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h00, 32'hFFFFFFFF);
        @(posedge clk); #1;
        @(negedge clk);
        checkCount++;
        if (ack !== 1'b1 || rdata !== 32'hA5A5A5A5)
            $display("[TB] FAIL busy_change: got ack %b rdata %h required 1 a5a5a5a5", ack, rdata);
        else passCount++;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        runAccess(1'b0, 1'b1, 32'h14, 32'h11112222);
        @(negedge clk);
        checkCount++;
        if (rdata !== 32'hA5A5A5A5)
            $display("[TB] FAIL busy_hold: got rdata %h required a5a5a5a5", rdata);
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_store();
        drive(1'b0, 1'b1, 32'h08, 32'h12345678);
        @(negedge clk);
        checkCount++;
        if (stall !== 1'b1)
            $display("[TB] FAIL midstore_accept: got stall %b required 1", stall);
        else passCount++;
        @(posedge clk); #1;
        startN = 1'b0;
        @(posedge clk); #1;
        startN = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        clearModel();
        @(negedge clk);
        checkCount++;
        if ({stall, ack} !== 2'b00 || rdata !== 32'd0)
            $display("[TB] FAIL midstore_idle: got stall/ack %b rdata %h required 00 0", {stall, ack}, rdata);
        else passCount++;
        @(posedge clk); #1;
        runAccess(1'b1, 1'b0, 32'h08, 32'h0);
        runAccess(1'b1, 1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_latency1();
        logic [31:0] lastVal;
        lastVal = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                lastVal = $urandom;
                rd1 = 1'b0; wr1 = 1'b1; wdata1 = lastVal;
            end else begin
                rd1 = 1'b1; wr1 = 1'b0; wdata1 = 32'd0;
            end
            addr1 = 32'h04;
            @(negedge clk);
            checkCount++;
            if (stall1 !== 1'b0 || ack1 !== 1'b1)
                $display("[TB] FAIL lat1_flags_%0d: got stall %b ack %b required 0 1", i, stall1, ack1);
            else passCount++;
            if (i % 2 == 1) begin
                checkCount++;
                if (rdata1 !== lastVal)
                    $display("[TB] FAIL lat1_load_%0d: got %h required %h", i, rdata1, lastVal);
                else passCount++;
            end
            @(posedge clk); #1;
        end
        rd1 = 1'b0; wr1 = 1'b0;
        @(negedge clk);
        checkCount++;
        if (rdata1 !== lastVal || ack1 !== 1'b0)
            $display("[TB] FAIL lat1_hold: got rdata %h ack %b required %h 0", rdata1, ack1, lastVal);
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            logic isWr;
            isWr = ($urandom_range(0, 1) == 1);
            issue(!isWr, isWr, 32'($urandom_range(0, 31) * 4), $urandom);
            repeat (LAT) @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (sbq.size() != 0)
            $display("[TB] FAIL sb_drain: got %0d outstanding accesses required 0", sbq.size());
        else passCount++;
    endtask

    initial begin
        clk = 1'b0;
        startN = 1'b0;
        passCount = 0;
        checkCount = 0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        clearModel();
        test_reset();
        test_store_load();
        test_illegal();
        test_busy_change();
        test_reset_mid_store();
        test_latency1();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
